multicycle_controller: RTL and testbench

- FSM controller that sequences a shared-memory, multi-cycle RV32I datapath.
- The datapath is the same ALU, register file and extender set as the single-cycle core, plus IR, OldPC, Data and ALUOut registers.
- A single memory port is used for both fetch and load/store, with a ready handshake for variable-latency memory.
- Decodes the opcode/funct fields from IR each cycle and issues mux selects, register enables and ALU control.

---
 rtl/riscv_ctrl_pkg.sv | 92 +++++++++
 rtl/alu_decoder.sv | 41 ++++
 rtl/multicycle_controller.sv | 202 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states, opcodes,
// and the select/control codes driven into the datapath.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_JALR_LINK,
    S_LUI,
    S_AUIPC
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLT   = 4'b0101,
    ALU_SLTU  = 4'b0110,
    ALU_SLL   = 4'b0111,
    ALU_SRL   = 4'b1000,
    ALU_SRA   = 4'b1001,
    ALU_PASSB = 4'b1010
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_DATA      = 2'b01,
    RES_ALURESULT = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RD1   = 2'b10
  } src_a_e;

  typedef enum logic [1:0] {
    SRCB_RD2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } src_b_e;

  // Undecodable opcodes fall back to the I-format; the instruction is trapped anyway.
  function automatic imm_src_e imm_for_op(input logic [6:0] op);
    case (op)
      OP_STORE:         return IMM_S;
      OP_BRANCH:        return IMM_B;
      OP_JAL:           return IMM_J;
      OP_LUI, OP_AUIPC: return IMM_U;
      default:          return IMM_I;
    endcase
  endfunction

  function automatic logic is_legal_op(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps op/funct3/funct7b5 to an ALU operation; branches get the compare op
// that makes the zero flag meaningful for the taken decision.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] i_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  output logic [3:0] o_alu_control
);

  always_comb begin
    o_alu_control = ALU_ADD;
    if (i_op == OP_BRANCH) begin
      case (i_funct3[2:1])
        2'b10:   o_alu_control = ALU_SLT;
        2'b11:   o_alu_control = ALU_SLTU;
        default: o_alu_control = ALU_SUB;
      endcase
    end else begin
      case (i_funct3)
        3'b000: begin
          // funct7b5 only selects SUB for register-register ops; addi ignores it.
          if (i_op == OP_RTYPE && i_funct7b5) o_alu_control = ALU_SUB;
          else                                o_alu_control = ALU_ADD;
        end
        3'b001: o_alu_control = ALU_SLL;
        3'b010: o_alu_control = ALU_SLT;
        3'b011: o_alu_control = ALU_SLTU;
        3'b100: o_alu_control = ALU_XOR;
        3'b101: begin
          if (i_funct7b5) o_alu_control = ALU_SRA;
          else            o_alu_control = ALU_SRL;
        end
        3'b110: o_alu_control = ALU_OR;
        default: o_alu_control = ALU_AND;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// FSM sequencing a shared-memory multi-cycle RV32I datapath, with a ready
// handshake on the single memory port.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [3:0] alu_control,
  output logic       jalr,
  output logic       illegal_instr,
  output logic       instr_retire
);

  state_e     r_state;
  state_e     w_next;
  logic [3:0] w_alu_dec;
  logic       w_br_taken;
  logic       w_br_illegal;

  alu_decoder u_alu_decoder (
    .i_op          (op),
    .i_funct3      (funct3),
    .i_funct7b5    (funct7b5),
    .o_alu_control (w_alu_dec)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECR;
          OP_ITYPE:          w_next = S_EXECI;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          OP_JALR:           w_next = S_JALR;
          OP_LUI:            w_next = S_LUI;
          OP_AUIPC:          w_next = S_AUIPC;
          default:           w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LOAD) w_next = S_MEMREAD;
        else               w_next = S_MEMWRITE;
      end
      S_MEMREAD:   if (mem_ready) w_next = S_MEMWB;
      S_MEMWRITE:  if (mem_ready) w_next = S_FETCH;
      S_MEMWB:     w_next = S_FETCH;
      S_EXECR:     w_next = S_ALUWB;
      S_EXECI:     w_next = S_ALUWB;
      S_ALUWB:     w_next = S_FETCH;
      S_BRANCH:    w_next = S_FETCH;
      S_JAL:       w_next = S_ALUWB;
      S_JALR:      w_next = S_JALR_LINK;
      S_JALR_LINK: w_next = S_ALUWB;
      S_LUI:       w_next = S_ALUWB;
      S_AUIPC:     w_next = S_ALUWB;
      default:     w_next = S_FETCH;
    endcase
  end

  // The branch ALU op leaves zero=1 for "equal" (SUB) or "not less" (SLT/SLTU).
  always_comb begin
    w_br_taken   = 1'b0;
    w_br_illegal = 1'b0;
    case (funct3)
      3'b000:         w_br_taken   = zero;
      3'b001:         w_br_taken   = ~zero;
      3'b100, 3'b110: w_br_taken   = ~zero;
      3'b101, 3'b111: w_br_taken   = zero;
      default:        w_br_illegal = 1'b1;
    endcase
  end

  always_comb begin
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    result_src    = RES_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RD2;
    imm_src       = imm_for_op(op);
    alu_control   = ALU_ADD;
    jalr          = 1'b0;
    illegal_instr = 1'b0;
    instr_retire  = 1'b0;
    if (reset) begin
      // FETCH selects with every strobe held off, whatever state is being abandoned.
      alu_src_b  = SRCB_FOUR;
      result_src = RES_ALURESULT;
    end else begin
      case (r_state)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALURESULT;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        S_DECODE: begin
          alu_src_a     = SRCA_OLDPC;
          alu_src_b     = SRCB_IMM;
          illegal_instr = ~is_legal_op(op);
          instr_retire  = ~is_legal_op(op);
        end
        S_MEMADR: begin
          alu_src_a = SRCA_RD1;
          alu_src_b = SRCB_IMM;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        S_MEMWB: begin
          result_src   = RES_DATA;
          reg_write    = 1'b1;
          instr_retire = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req      = 1'b1;
          mem_write    = 1'b1;
          adr_src      = 1'b1;
          instr_retire = mem_ready;
        end
        S_EXECR: begin
          alu_src_a   = SRCA_RD1;
          alu_control = w_alu_dec;
        end
        S_EXECI: begin
          alu_src_a   = SRCA_RD1;
          alu_src_b   = SRCB_IMM;
          alu_control = w_alu_dec;
        end
        S_ALUWB: begin
          reg_write    = 1'b1;
          instr_retire = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = SRCA_RD1;
          alu_control   = w_alu_dec;
          pc_write      = w_br_taken;
          illegal_instr = w_br_illegal;
          instr_retire  = 1'b1;
        end
        S_JAL: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_FOUR;
          pc_write  = 1'b1;
        end
        S_JALR: begin
          alu_src_a  = SRCA_RD1;
          alu_src_b  = SRCB_IMM;
          result_src = RES_ALURESULT;
          jalr       = 1'b1;
          pc_write   = 1'b1;
        end
        S_JALR_LINK: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_FOUR;
        end
        S_LUI: begin
          alu_src_b   = SRCB_IMM;
          alu_control = ALU_PASSB;
        end
        S_AUIPC: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
        end
        default: begin
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALURESULT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed and randomized bench for multicycle_controller, checked every cycle
// against an instruction-step model of the controller's observable behaviour.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src;
  logic [3:0] alu_control;
  logic       jalr, illegal_instr, instr_retire;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk           (clk),
    .reset         (reset),
    .op            (op),
    .funct3        (funct3),
    .funct7b5      (funct7b5),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .mem_write     (mem_write),
    .adr_src       (adr_src),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .reg_write     (reg_write),
    .result_src    (result_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .imm_src       (imm_src),
    .alu_control   (alu_control),
    .jalr          (jalr),
    .illegal_instr (illegal_instr),
    .instr_retire  (instr_retire)
  );

  typedef enum int {K_LOAD, K_STORE, K_RALU, K_IALU, K_BRANCH, K_JAL, K_JALR,
                    K_LUI, K_AUIPC, K_ILLEGAL} kind_e;

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
  } instr_t;

  // en = {mem_req, mem_write, ir_write, pc_write, reg_write, jalr, illegal, retire}
  typedef struct packed {
    logic [7:0] en;
    logic [3:0] alu;
    bit         careAlu;
    logic       adr;
    bit         careAdr;
    logic [1:0] res;
    bit         careRes;
    logic [1:0] srcA;
    bit         careA;
    logic [1:0] srcB;
    bit         careB;
    int         nextStep;
  } expect_t;

  instr_t instrQ[$];
  int     checks = 0;
  int     errors = 0;
  int     mStep  = 0;
  kind_e  mKind  = K_ILLEGAL;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
    end
  endtask

  function automatic kind_e classify(input logic [6:0] o);
    case (o)
      7'b0000011: return K_LOAD;
      7'b0100011: return K_STORE;
      7'b0110011: return K_RALU;
      7'b0010011: return K_IALU;
      7'b1100011: return K_BRANCH;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      7'b0110111: return K_LUI;
      7'b0010111: return K_AUIPC;
      default:    return K_ILLEGAL;
    endcase
  endfunction

  function automatic logic [2:0] immFor(input kind_e k);
    case (k)
      K_STORE:         return 3'b001;
      K_BRANCH:        return 3'b010;
      K_JAL:           return 3'b011;
      K_LUI, K_AUIPC:  return 3'b100;
      default:         return 3'b000;
    endcase
  endfunction

  function automatic logic [3:0] execAlu(input kind_e k, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0:    return (k == K_RALU && f7) ? 4'b0001 : 4'b0000;
      3'd1:    return 4'b0111;
      3'd2:    return 4'b0101;
      3'd3:    return 4'b0110;
      3'd4:    return 4'b0100;
      3'd5:    return f7 ? 4'b1001 : 4'b1000;
      3'd6:    return 4'b0011;
      default: return 4'b0010;
    endcase
  endfunction

  // Step 0 is the fetch, step 1 the decode; later steps follow the instruction class.
  function automatic expect_t predict(input int step, input kind_e kind, input logic rst,
                                      input logic z, input logic rdy,
                                      input logic [2:0] f3, input logic f7);
    expect_t e;
    logic memReq, memWrite, irWrite, pcWrite, regWrite, jl, ill, ret;
    int lastStep;
    {memReq, memWrite, irWrite, pcWrite, regWrite, jl, ill, ret} = 8'b0;
    e = '0;
    e.careAlu  = 1'b1;
    e.alu      = 4'b0000;
    e.nextStep = step + 1;
    lastStep   = (kind == K_JALR) ? 4 : 3;
    if (rst) begin
      e.careAdr = 1'b1; e.adr  = 1'b0;
      e.careA   = 1'b1; e.srcA = 2'b00;
      e.careB   = 1'b1; e.srcB = 2'b10;
      e.careRes = 1'b1; e.res  = 2'b10;
      e.nextStep = 0;
    end else if (step == 0) begin
      memReq = 1'b1; irWrite = rdy; pcWrite = rdy;
      e.careAdr = 1'b1; e.adr  = 1'b0;
      e.careA   = 1'b1; e.srcA = 2'b00;
      e.careB   = 1'b1; e.srcB = 2'b10;
      e.careRes = 1'b1; e.res  = 2'b10;
      e.nextStep = rdy ? 1 : 0;
    end else if (step == 1) begin
      e.careA = 1'b1; e.srcA = 2'b01;
      e.careB = 1'b1; e.srcB = 2'b01;
      if (kind == K_ILLEGAL) begin
        ill = 1'b1; ret = 1'b1; e.nextStep = 0;
      end
    end else if (kind == K_LOAD || kind == K_STORE) begin
      if (step == 2) begin
        e.careA = 1'b1; e.srcA = 2'b10;
        e.careB = 1'b1; e.srcB = 2'b01;
      end else if (step == 3) begin
        memReq = 1'b1;
        e.careAdr = 1'b1; e.adr = 1'b1;
        e.careRes = 1'b1; e.res = 2'b00;
        if (kind == K_STORE) begin
          memWrite = 1'b1; ret = rdy; e.nextStep = rdy ? 0 : 3;
        end else begin
          e.nextStep = rdy ? 4 : 3;
        end
      end else begin
        e.careRes = 1'b1; e.res = 2'b01;
        regWrite = 1'b1; ret = 1'b1; e.nextStep = 0;
      end
    end else if (kind == K_BRANCH) begin
      e.careA = 1'b1; e.srcA = 2'b10;
      e.careB = 1'b1; e.srcB = 2'b00;
      e.careRes = 1'b1; e.res = 2'b00;
      ret = 1'b1; e.nextStep = 0;
      case (f3[2:1])
        2'b00:   e.alu = 4'b0001;
        2'b10:   e.alu = 4'b0101;
        2'b11:   e.alu = 4'b0110;
        default: begin e.careAlu = 1'b0; ill = 1'b1; end
      endcase
      case (f3)
        3'b000, 3'b101, 3'b111: pcWrite = z;
        3'b001, 3'b100, 3'b110: pcWrite = ~z;
        default:                pcWrite = 1'b0;
      endcase
    end else if (step == lastStep) begin
      e.careRes = 1'b1; e.res = 2'b00;
      regWrite = 1'b1; ret = 1'b1; e.nextStep = 0;
    end else begin
      case (kind)
        K_RALU, K_IALU: begin
          e.careA = 1'b1; e.srcA = 2'b10;
          e.careB = 1'b1; e.srcB = (kind == K_RALU) ? 2'b00 : 2'b01;
          e.alu = execAlu(kind, f3, f7);
        end
        K_JAL: begin
          e.careA = 1'b1; e.srcA = 2'b01;
          e.careB = 1'b1; e.srcB = 2'b10;
          e.careRes = 1'b1; e.res = 2'b00;
          pcWrite = 1'b1;
        end
        K_JALR: begin
          if (step == 2) begin
            e.careA = 1'b1; e.srcA = 2'b10;
            e.careB = 1'b1; e.srcB = 2'b01;
            e.careRes = 1'b1; e.res = 2'b10;
            jl = 1'b1; pcWrite = 1'b1;
          end else begin
            e.careA = 1'b1; e.srcA = 2'b01;
            e.careB = 1'b1; e.srcB = 2'b10;
          end
        end
        K_LUI: begin
          e.careB = 1'b1; e.srcB = 2'b01;
          e.alu = 4'b1010;
        end
        default: begin
          e.careA = 1'b1; e.srcA = 2'b01;
          e.careB = 1'b1; e.srcB = 2'b01;
        end
      endcase
    end
    e.en = {memReq, memWrite, irWrite, pcWrite, regWrite, jl, ill, ret};
    return e;
  endfunction

  task automatic compareModel();
    expect_t e;
    kind_e   curKind;
    string   tag;
    if (mStep == 1) mKind = classify(op);
    e = predict(mStep, mKind, reset, zero, mem_ready, funct3, funct7b5);
    tag = $sformatf("step%0d", mStep);
    checkOutput({tag, " strobes"}, 32'({mem_req, mem_write, ir_write, pc_write, reg_write,
                                          jalr, illegal_instr, instr_retire}), 32'(e.en));
    if (e.careAlu) checkOutput({tag, " alu_control"}, 32'(alu_control), 32'(e.alu));
    if (e.careAdr) checkOutput({tag, " adr_src"}, 32'(adr_src), 32'(e.adr));
    if (e.careRes) checkOutput({tag, " result_src"}, 32'(result_src), 32'(e.res));
    if (e.careA)   checkOutput({tag, " alu_src_a"}, 32'(alu_src_a), 32'(e.srcA));
    if (e.careB)   checkOutput({tag, " alu_src_b"}, 32'(alu_src_b), 32'(e.srcB));
    curKind = classify(op);
    if (curKind != K_ILLEGAL) checkOutput({tag, " imm_src"}, 32'(imm_src), 32'(immFor(curKind)));
    mStep = e.nextStep;
  endtask

  function automatic instr_t randInstr();
    instr_t ins;
    logic [6:0] legal [9];
    logic [6:0] bad [3];
    legal = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    bad   = '{7'b0000000, 7'b1111111, 7'b0001111};
    if ($urandom_range(0, 9) == 0) ins.op = bad[$urandom_range(0, 2)];
    else                           ins.op = legal[$urandom_range(0, 8)];
    ins.f3 = 3'($urandom_range(0, 7));
    ins.f7 = ($urandom_range(0, 1) == 1);
    return ins;
  endfunction

  // One clock: inputs change just after the edge, outputs are judged at the falling edge.
  task automatic applyStimulus(input bit rst, input bit z, input bit rdy);
    instr_t ins;
    @(posedge clk);
    #1;
    if (mStep == 1) begin
      if (instrQ.size() > 0) ins = instrQ.pop_front();
      else                   ins = randInstr();
      op = ins.op; funct3 = ins.f3; funct7b5 = ins.f7;
    end
    reset = rst; zero = z; mem_ready = rdy;
    @(negedge clk);
    compareModel();
  endtask

  initial begin
    reset = 1'b1; zero = 1'b0; mem_ready = 1'b0;
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;

    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("reset mem_req", 32'(mem_req), 32'd0);

    // add x3,x1,x2
    instrQ.push_back('{7'b0110011, 3'b000, 1'b0});
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("add fetch ir_write", 32'(ir_write), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("add decode retire", 32'(instr_retire), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("add exec alu", 32'(alu_control), 32'h0);
    checkOutput("add exec srcb", 32'(alu_src_b), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("add wb reg_write", 32'(reg_write), 32'd1);
    checkOutput("add cycle4 retire", 32'(instr_retire), 32'd1);

    // lw with three stall cycles
    instrQ.push_back('{7'b0000011, 3'b010, 1'b0});
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("lw stall mem_req", 32'(mem_req), 32'd1);
      checkOutput("lw stall reg_write", 32'(reg_write), 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("lw read retire", 32'(instr_retire), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("lw wb reg_write", 32'(reg_write), 32'd1);
    checkOutput("lw wb result_src", 32'(result_src), 32'h1);
    checkOutput("lw cycle8 retire", 32'(instr_retire), 32'd1);

    // beq taken, bltu not taken, funct3=010 illegal
    instrQ.push_back('{7'b1100011, 3'b000, 1'b0});
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("beq pc_write", 32'(pc_write), 32'd1);
    instrQ.push_back('{7'b1100011, 3'b110, 1'b0});
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("bltu pc_write", 32'(pc_write), 32'd0);
    checkOutput("bltu alu", 32'(alu_control), 32'h6);
    instrQ.push_back('{7'b1100011, 3'b010, 1'b0});
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("branch f3=010 illegal", 32'(illegal_instr), 32'd1);

    // jalr
    instrQ.push_back('{7'b1100111, 3'b000, 1'b0});
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("jalr pc_write", 32'(pc_write), 32'd1);
    checkOutput("jalr jalr", 32'(jalr), 32'd1);
    checkOutput("jalr result_src", 32'(result_src), 32'h2);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("jalr link reg_write", 32'(reg_write), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("jalr cycle5 retire", 32'(instr_retire), 32'd1);

    // op=0000000 traps in decode
    instrQ.push_back('{7'b0000000, 3'b000, 1'b0});
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("illegal op pulse", 32'(illegal_instr), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("illegal op refetch", 32'(mem_req), 32'd1);

    // srai
    instrQ.push_back('{7'b0010011, 3'b101, 1'b1});
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("srai alu", 32'(alu_control), 32'h9);
    applyStimulus(1'b0, 1'b0, 1'b1);

    // sw abandoned by a 3-cycle reset while stalled in the write
    instrQ.push_back('{7'b0100011, 3'b010, 1'b0});
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("sw mem_write", 32'(mem_write), 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("sw reset mem_write", 32'(mem_write), 32'd0);
      checkOutput("sw reset mem_req", 32'(mem_req), 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("post-reset mem_req", 32'(mem_req), 32'd1);
    checkOutput("post-reset ir_write", 32'(ir_write), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1),
                    ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
